alu_issue_stage: RTL and testbench

Upstream issue stage for the combinational `alu`.
- Accepts `{opcode, a, b}` operations over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's `opcode`/`a`/`b` inputs from registers, allows one settle cycle, then captures `c`.
- Presents the result with its originating operation on a valid/ready output port.
- Sits between the stimulus/instruction source and the ALU, and owns all sequencing of ALU inputs.

---
 rtl/alu_issue_stage.sv | 204 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operation FIFO and issue/capture sequencer for the combinational alu
// Optional 1-cycle FIFO bypass when idle and empty: define ALU_ISSUE_BYPASS_EN.

package alu_issue_pkg;
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } opcode_e;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_e          in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output opcode_e          alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output opcode_e          out_opcode,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    opcode_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_e           state_q, state_d;
  op_t              mem_q [DEPTH];
  op_t              mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  opcode_e          alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic             out_valid_q, out_valid_d;
  opcode_e          out_opcode_q, out_opcode_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;

  logic full, empty, push, push_fifo, pop, bypass;
  op_t  head, in_op;

  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    in_ready  = !full;
    push      = in_valid && !full;
    head      = mem_q[rd_ptr_q];
    in_op.op  = in_opcode;
    in_op.a   = in_a;
    in_op.b   = in_b;

    pop          = 1'b0;
    bypass       = 1'b0;
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_c_d      = out_c_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          alu_opcode_d = head.op;
          alu_a_d      = head.a;
          alu_b_d      = head.b;
          state_d      = S_EXEC;
        end
`ifdef ALU_ISSUE_BYPASS_EN
        else if (push) begin
          bypass       = 1'b1;
          alu_opcode_d = in_opcode;
          alu_a_d      = in_a;
          alu_b_d      = in_b;
          state_d      = S_EXEC;
        end
`endif
      end
      S_EXEC: begin
        // ALU inputs have had a full cycle to settle; alu_c is valid now.
        out_opcode_d = alu_opcode_q;
        out_a_d      = alu_a_q;
        out_b_d      = alu_b_q;
        out_c_d      = alu_c;
        out_valid_d  = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop          = 1'b1;
            alu_opcode_d = head.op;
            alu_a_d      = head.a;
            alu_b_d      = head.b;
            state_d      = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_fifo = push && !bypass;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_fifo) begin
      mem_d[wr_ptr_q] = in_op;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves the level unchanged.
    count_d = count_q;
    if (push_fifo && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_fifo) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= opcode_e'(0);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= opcode_e'(0);
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_c_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_c_q      <= out_c_d;
      mem_q        <= mem_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_c      = out_c_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage with a behavioural alu
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  opcode_e    in_opcode;
  logic [3:0] in_a, in_b;
  opcode_e    alu_opcode;
  logic [3:0] alu_a, alu_b, alu_c;
  logic       out_valid;
  logic       out_ready;
  opcode_e    out_opcode;
  logic [3:0] out_a, out_b, out_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_c = '0;
    case (alu_opcode)
      ADD: alu_c = alu_a + alu_b;
      SUB: alu_c = alu_a - alu_b;
      AND: alu_c = alu_a & alu_b;
      OR:  alu_c = alu_a | alu_b;
      default: alu_c = '0;
    endcase
  end

  alu_issue_stage #(.DEPTH(4), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_c(out_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if ({out_a, out_b, out_c} !== 12'h000) begin errors++; $display("FAIL reset_out_abc got %h want 000", {out_a, out_b, out_c}); end
    checks++; if (out_opcode !== ADD) begin errors++; $display("FAIL reset_out_opcode got %0d want 0", out_opcode); end
    checks++; if ({alu_a, alu_b} !== 8'h00) begin errors++; $display("FAIL reset_alu_ab got %h want 00", {alu_a, alu_b}); end
    checks++; if (alu_opcode !== ADD) begin errors++; $display("FAIL reset_alu_opcode got %0d want 0", alu_opcode); end
  endtask

  task automatic send_and_wait(input opcode_e op, input logic [3:0] a, input logic [3:0] b, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
  endtask

  task automatic test_basic();
    int lat;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", in_ready); end
    send_and_wait(ADD, 4'h2, 4'h1, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++; if (out_c !== 4'h3) begin errors++; $display("FAIL basic_out_c got %h want 3", out_c); end
    checks++; if (out_opcode !== ADD) begin errors++; $display("FAIL basic_out_opcode got %0d want 0", out_opcode); end
    checks++; if ({out_a, out_b} !== 8'h21) begin errors++; $display("FAIL basic_out_ab got %h want 21", {out_a, out_b}); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    int lat;
    send_and_wait(ADD, 4'hF, 4'h1, lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_out_valid got %0b want 1", out_valid); end
    checks++; if (out_c !== 4'h0) begin errors++; $display("FAIL wrap_out_c got %h want 0", out_c); end
    checks++; if ({out_a, out_b} !== 8'hF1) begin errors++; $display("FAIL wrap_out_ab got %h want f1", {out_a, out_b}); end
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] a_tbl [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    logic [3:0] exp_a [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    logic [3:0] exp_c [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    int idx = 0;
    int n;
    logic acc;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid  = (idx < 7);
      in_opcode = ADD;
      in_a      = a_tbl[(idx < 7) ? idx : 6];
      in_b      = 4'h1;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    checks++; if (idx !== 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!out_valid && n < 8) begin step(); n++; end
      checks++; if ({out_valid, out_a, out_c} !== {1'b1, exp_a[j], exp_c[j]}) begin errors++; $display("FAIL bp_result%0d got v=%0b a=%h c=%h want v=1 a=%h c=%h", j, out_valid, out_a, out_c, exp_a[j], exp_c[j]); end
      step();
      checks++; if ({out_valid, out_a, out_c} !== {1'b1, exp_a[j], exp_c[j]}) begin errors++; $display("FAIL bp_stable%0d got v=%0b a=%h c=%h want v=1 a=%h c=%h", j, out_valid, out_a, out_c, exp_a[j], exp_c[j]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra got %0b want 0", out_valid); end
  endtask

  task automatic test_all_opcodes();
    opcode_e    ops   [4] = '{ADD, SUB, AND, OR};
    logic [3:0] exp_c [4] = '{4'h3, 4'h1, 4'h0, 4'h3};
    int idx = 0, rx = 0, last = 0;
    logic acc;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) begin
        if (rx < 4) begin
          checks++; if ({out_opcode, out_a, out_b, out_c} !== {ops[rx], 4'h2, 4'h1, exp_c[rx]}) begin errors++; $display("FAIL ops_result%0d got op=%0d a=%h b=%h c=%h want op=%0d a=2 b=1 c=%h", rx, out_opcode, out_a, out_b, out_c, ops[rx], exp_c[rx]); end
          if (rx > 0) begin
            checks++; if (cyc - last !== 2) begin errors++; $display("FAIL ops_spacing%0d got %0d want 2", rx, cyc - last); end
          end
        end else begin
          checks++; errors++; $display("FAIL ops_extra got result %0d want none", rx);
        end
        last = cyc;
        rx++;
      end
      in_valid  = (idx < 4);
      in_opcode = ops[(idx < 4) ? idx : 3];
      in_a      = 4'h2;
      in_b      = 4'h1;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    checks++; if (rx !== 4) begin errors++; $display("FAIL ops_count got %0d want 4", rx); end
  endtask

  task automatic test_full_stream();
    logic [3:0] a_tbl [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] exp_c [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    int sent = 0, rx = 0, n = 0;
    logic acc, hs, prev_hs, ir;
    out_ready = 1'b0;
    in_opcode = ADD;
    in_b      = 4'h1;
    while (in_ready && n < 12) begin
      in_valid = 1'b1;
      in_a     = a_tbl[sent];
      step();
      sent++;
      n++;
    end
    checks++; if (sent !== 5) begin errors++; $display("FAIL full_fill got %0d want 5", sent); end
    out_ready = 1'b1;
    prev_hs = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      hs = out_valid && out_ready;
      ir = in_ready;
      if (sent < 9) begin
        checks++; if (ir !== prev_hs) begin errors++; $display("FAIL full_ready_cyc%0d got %0b want %0b", cyc, ir, prev_hs); end
      end
      if (hs) begin
        if (rx < 9) begin
          checks++; if ({out_a, out_c} !== {a_tbl[rx], exp_c[rx]}) begin errors++; $display("FAIL full_result%0d got a=%h c=%h want a=%h c=%h", rx, out_a, out_c, a_tbl[rx], exp_c[rx]); end
        end
        rx++;
      end
      in_valid = (sent < 9);
      in_a     = a_tbl[(sent < 9) ? sent : 8];
      acc = in_valid && ir;
      step();
      if (acc) sent++;
      prev_hs = hs;
    end
    checks++; if (sent !== 9) begin errors++; $display("FAIL full_sent got %0d want 9", sent); end
    checks++; if (rx !== 9) begin errors++; $display("FAIL full_received got %0d want 9", rx); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int sent = 0, n = 0;
    logic acc;
    out_ready = 1'b0;
    in_opcode = SUB;
    in_b      = 4'h2;
    while (sent < 5 && n < 12) begin
      in_valid = 1'b1;
      in_a     = 4'(sent + 1);
      acc = in_ready;
      step();
      if (acc) sent++;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if ({out_valid, alu_a} !== {1'b0, 4'h2}) begin errors++; $display("FAIL rst_pre_exec got v=%0b alu_a=%h want v=0 alu_a=2", out_valid, alu_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== {ADD, 8'h00}) begin errors++; $display("FAIL rst_alu got op=%0d a=%h b=%h want op=0 a=0 b=0", alu_opcode, alu_a, alu_b); end
    checks++; if ({out_a, out_b, out_c} !== 12'h000) begin errors++; $display("FAIL rst_out_abc got %h want 000", {out_a, out_b, out_c}); end
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_cyc%0d got %0b want 0", cyc, out_valid); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = ADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_all_opcodes();
    test_full_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
